// File: rtl/bus_arbiter_server.sv
// Server end of the client rq/ack bus: arbitrates among NUM_CLIENTS requesters,
// executes the winner's read/write on an internal register file and pulses ack.
// Optional build macro ARB_FIXED_PRIORITY_EN selects fixed priority (lowest index
// wins, pointer held at 0); when undefined the arbiter is round-robin.
module bus_arbiter_server #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            rq,
  input  logic [NUM_CLIENTS-1:0]            wr_ni,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_CLIENTS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [2:0]                        grant_id,
  output logic                              busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, ACK} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [2:0]              ptr;
  logic [2:0]              ptr_next;
  logic [2:0]              winner;
  logic [3:0]              arb_cand;
  logic                    arb_found;
  logic                    sel_wr_ni;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    cmd_wr_ni;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Search from ptr, wrapping modulo NUM_CLIENTS; first requester found wins.
  always_comb begin
    winner    = 3'd0;
    arb_found = 1'b0;
    arb_cand  = 4'd0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      arb_cand = {1'b0, ptr} + 4'(k);
      if (arb_cand >= 4'(NUM_CLIENTS))
        arb_cand = arb_cand - 4'(NUM_CLIENTS);
      for (int j = 0; j < NUM_CLIENTS; j++) begin
        if (!arb_found && rq[j] && (arb_cand == 4'(j))) begin
          winner    = 3'(j);
          arb_found = 1'b1;
        end
      end
    end
`ifdef ARB_FIXED_PRIORITY_EN
    ptr_next = 3'd0;
`else
    ptr_next = (winner == 3'(NUM_CLIENTS-1)) ? 3'd0 : winner + 3'd1;
`endif
  end

  // Pick the winning client's command fields out of the flat buses.
  always_comb begin
    sel_wr_ni = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int j = 0; j < NUM_CLIENTS; j++) begin
      if (winner == 3'(j)) begin
        sel_wr_ni = wr_ni[j];
        sel_addr  = addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic plus ack/busy decode; ack only ever fires in ACK.
  always_comb begin
    state_next = state;
    ack        = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (|rq) state_next = GRANT;
      GRANT:   state_next = ACCESS;
      ACCESS:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state == ACK) begin
      for (int j = 0; j < NUM_CLIENTS; j++) begin
        if (grant_id == 3'(j)) ack[j] = 1'b1;
      end
    end
  end

  // State register, winner/command capture in GRANT and read result in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      grant_id  <= 3'd0;
      cmd_wr_ni <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      rd_data   <= '0;
    end else begin
      state <= state_next;
      if (state == GRANT) begin
        grant_id  <= winner;
        ptr       <= ptr_next;
        cmd_wr_ni <= sel_wr_ni;
        cmd_addr  <= sel_addr;
        cmd_data  <= sel_data;
      end
      if (state == ACCESS && cmd_wr_ni)
        rd_data <= mem[cmd_addr];
    end
  end

  // Register-file storage; a reset clears every word and drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ACCESS && !cmd_wr_ni) begin
      mem[cmd_addr] <= cmd_data;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_server.sv
// Scoreboard bench for bus_arbiter_server: a transaction-level model predicts the
// service order and read data of each batch of requests; a monitor checks acks.
module tb_bus_arbiter_server;

  localparam int NC = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    rq;
  logic [NC-1:0]    wr_ni;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wr_data;
  logic [NC-1:0]    ack;
  logic [DW-1:0]    rd_data;
  logic [2:0]       grant_id;
  logic             busy;

  typedef struct {
    int            id;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          expQ[$];
  exp_t          monE;
  int            checkCount = 0;
  int            passCount  = 0;
  logic [DW-1:0] memModel [16];
  int            ptrModel;
  logic [DW-1:0] lastRdModel;
  int            lastIdModel;

  bus_arbiter_server #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rq(rq), .wr_ni(wr_ni), .addr(addr), .wr_data(wr_data),
    .ack(ack), .rd_data(rd_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 16; i++) memModel[i] = '0;
    ptrModel    = 0;
    lastRdModel = '0;
    lastIdModel = 0;
  endtask

  function automatic int pickNext(input logic [NC-1:0] pend);
    int idx;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < NC; k++)
      if (((pend >> k) & NC'(1)) != 0) return k;
`else
    for (int k = 0; k < NC; k++) begin
      idx = (ptrModel + k) % NC;
      if (((pend >> idx) & NC'(1)) != 0) return idx;
    end
`endif
    return -1;
  endfunction

  // Drive a batch of simultaneous requests and predict every resulting ack.
  task automatic applyStimulus(input logic [NC-1:0] mask, input logic [NC-1:0] cmdRead,
                               input logic [NC*AW-1:0] addrs, input logic [NC*DW-1:0] datas);
    logic [NC-1:0] pend;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            id;
    exp_t          e;
    wr_ni   = cmdRead;
    addr    = addrs;
    wr_data = datas;
    rq      = mask;
    pend    = mask;
    while (pend != 0) begin
      id = pickNext(pend);
`ifndef ARB_FIXED_PRIORITY_EN
      ptrModel = (id + 1) % NC;
`endif
      a = AW'(addrs >> (id*AW));
      d = DW'(datas >> (id*DW));
      if (((cmdRead >> id) & NC'(1)) != 0) lastRdModel = memModel[a];
      else memModel[a] = d;
      e.id = id;
      e.rd = lastRdModel;
      expQ.push_back(e);
      lastIdModel = id;
      pend = pend & ~(NC'(1) << id);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    rq  = '0;
    expQ.delete();
    @(negedge clk);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_grant_id", grant_id, 0);
    rst = 1'b0;
    resetModel();
  endtask

  // Issue a batch, behave as the clients (drop rq on ack), and wait for completion.
  task automatic runRound(input logic [NC-1:0] mask, input logic [NC-1:0] cmdRead,
                          input logic [NC*AW-1:0] addrs, input logic [NC*DW-1:0] datas,
                          input int dropAt);
    int n = 0;
    applyStimulus(mask, cmdRead, addrs, datas);
    if ($countones(mask) == 1) begin
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        checkOutput("ack_latency", 32'(ack != '0), 32'(c == 3));
        if (c == dropAt) rq = '0;
        rq = rq & ~ack;
      end
    end
    #1;
    while ((expQ.size() != 0 || busy !== 1'b0) && n < 40) begin
      @(negedge clk);
      rq = rq & ~ack;
      n++;
      #1;
    end
    checkOutput("round_drained", expQ.size(), 0);
    if (expQ.size() != 0) doReset();
    else checkOutput("grant_id_hold", grant_id, lastIdModel);
  endtask

  // Scoreboard monitor: every ack must match the next predicted completion.
  always @(negedge clk) begin
    if (rst === 1'b0 && ack !== '0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_ack", ack, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("ack_onehot", ack, 32'(1) << monE.id);
        checkOutput("grant_id", grant_id, monE.id);
        checkOutput("rd_data", rd_data, monE.rd);
        checkOutput("busy_during_ack", busy, 1);
      end
    end
  end

  // Hard time limit so a stuck DUT cannot hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NC-1:0]    m;
    logic [NC-1:0]    r;
    logic [NC*AW-1:0] a;
    logic [NC*DW-1:0] d;
    rst = 1'b1; rq = '0; wr_ni = '0; addr = '0; wr_data = '0;
    resetModel();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset release.
    checkOutput("idle_grant_id", grant_id, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_ack", ack, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_rd_data", rd_data, 0);
    end

    // Client 1 writes 0xA5 to addr 3 then reads it back.
    runRound(4'b0010, 4'b0000, (NC*AW)'(3) << AW, (NC*DW)'(8'hA5) << DW, 0);
    runRound(4'b0010, 4'b0010, (NC*AW)'(3) << AW, '0, 0);

    // All four request at once: writes then reads of distinct addresses.
    runRound(4'b1111, 4'b0000, 16'h7654, 32'h44332211, 0);
    runRound(4'b1111, 4'b1111, 16'h4567, '0, 0);

    // Client 3 alone, then clients 0 and 3 together: pointer wraps to 0.
    runRound(4'b1000, 4'b1000, 16'h6000, '0, 0);
    runRound(4'b1001, 4'b1001, 16'h5004, '0, 0);

    // Client 2 drops rq during ACCESS; the write still lands.
    runRound(4'b0100, 4'b0000, 16'h0900, 32'h005A0000, 2);
    runRound(4'b0001, 4'b0001, 16'h0009, '0, 0);

    // Reset during ACCESS of a write to addr 5 aborts it and clears memory.
    runRound(4'b0001, 4'b0000, 16'h0005, 32'h00000077, 0);
    wr_ni = '0; addr = 16'h0005; wr_data = 32'h0000003C; rq = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rq  = '0;
    #1;
    checkOutput("abort_ack", ack, 0);
    checkOutput("abort_busy", busy, 0);
    @(negedge clk);
    checkOutput("abort_ack_held", ack, 0);
    rst = 1'b0;
    resetModel();
    runRound(4'b0001, 4'b0001, 16'h0005, '0, 0);

    // Randomized batches against the model.
    for (int t = 0; t < 40; t++) begin
      m = NC'($urandom_range(1, (1 << NC) - 1));
      r = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        a[i*AW +: AW] = AW'($urandom_range(0, (t % 2 == 0) ? 3 : 15));
        d[i*DW +: DW] = DW'($urandom);
      end
      runRound(m, r, a, d, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
